// File: rtl/fetch_pkg_buf.sv
// fetch_pkg_buf: store-and-forward packet buffer between fetch_top and a ready/valid consumer
//   clk_sys/rst          : single clock, synchronous active-high reset
//   pkg_data/pkg_vld/pkg_frm/len_pkg : incoming words, frm marks first word, len sampled at frm
//   out_data/out_vld/out_sop/out_eop/out_rdy : registered ready/valid output of committed packets
//   buf_level            : words held (uncommitted, committed and the one in the output register)
//   drop_cnt             : saturating drop/truncation count when FETCH_BUF_STAT_EN is defined, else 0
module fetch_pkg_buf #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic [15:0]           pkg_data,
    input  logic                  pkg_vld,
    input  logic                  pkg_frm,
    input  logic [15:0]           len_pkg,
    output logic [15:0]           out_data,
    output logic                  out_vld,
    output logic                  out_sop,
    output logic                  out_eop,
    input  logic                  out_rdy,
    output logic [DEPTH_LOG2:0]   buf_level,
    output logic [15:0]           drop_cnt
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    typedef logic [DEPTH_LOG2:0] ptr_t;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wst_t;
    logic [16:0] mem [DEPTH];
    logic [16:0] rd;
    ptr_t wptr, rptr, cptr, base, used, free, waddr;
    wst_t wst;
    logic [15:0] len_q, wcnt, data_q;
    logic start, trunc, admit, fill_wr, fill_last, we, weop, load;
    logic vld_q, sop_q, eop_q, sop_next;
    always_comb begin
        start     = pkg_vld && pkg_frm;
        trunc     = start && wst == W_FILL;
        // a truncating frm is judged against the space left after rewinding to the commit point
        base      = trunc ? cptr : wptr;
        used      = base - rptr;
        free      = ptr_t'(DEPTH) - used;
        admit     = start && len_pkg != 16'd0 && 17'(len_pkg) <= 17'(free);
        fill_wr   = pkg_vld && !pkg_frm && wst == W_FILL;
        fill_last = wcnt + 16'd1 == len_q;
        we        = admit || fill_wr;
        waddr     = admit ? base : wptr;
        weop      = admit ? len_pkg == 16'd1 : fill_last;
        rd        = mem[rptr[DEPTH_LOG2-1:0]];
        load      = rptr != cptr && (!vld_q || out_rdy);
    end
    always_ff @(posedge clk_sys) begin
        if (we) mem[waddr[DEPTH_LOG2-1:0]] <= {weop, pkg_data};
    end
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wst   <= W_IDLE;
            wptr  <= '0;
            cptr  <= '0;
            wcnt  <= '0;
            len_q <= '0;
        end else if (start) begin
            len_q <= len_pkg;
            wcnt  <= 16'd1;
            wptr  <= admit ? base + 1'b1 : base;
            if (admit && len_pkg == 16'd1) cptr <= base + 1'b1;
            wst   <= !admit ? W_DROP : len_pkg == 16'd1 ? W_IDLE : W_FILL;
        end else if (fill_wr) begin
            wptr <= wptr + 1'b1;
            wcnt <= wcnt + 16'd1;
            if (fill_last) begin
                cptr <= wptr + 1'b1;
                wst  <= W_IDLE;
            end
        end else if (wst == W_DROP) begin
            wcnt <= wcnt + 16'(pkg_vld);
            if (wcnt + 16'(pkg_vld) >= len_q) wst <= W_IDLE;
        end
    end
    // the output register doubles as the RAM read register; sop follows the previous word's eop
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            vld_q    <= 1'b0;
            data_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            rptr     <= '0;
            sop_next <= 1'b1;
        end else if (load) begin
            {eop_q, data_q} <= rd;
            sop_q    <= sop_next;
            sop_next <= rd[16];
            vld_q    <= 1'b1;
            rptr     <= rptr + 1'b1;
        end else if (out_rdy) begin
            vld_q <= 1'b0;
        end
    end
    assign out_vld   = vld_q && !rst;
    assign out_sop   = sop_q && !rst;
    assign out_eop   = eop_q && !rst;
    assign out_data  = rst ? '0 : data_q;
    assign buf_level = rst ? '0 : wptr - rptr + ptr_t'(vld_q);
`ifdef FETCH_BUF_STAT_EN
    logic [15:0] drop_q;
    logic [16:0] drop_sum;
    always_comb drop_sum = 17'(drop_q) + 17'(trunc) + 17'(start && !admit);
    always_ff @(posedge clk_sys) begin
        if (rst) drop_q <= '0;
        else drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
    assign drop_cnt = rst ? '0 : drop_q;
`else
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_pkg_buf.sv
// tb_fetch_pkg_buf: directed scoreboard bench for fetch_pkg_buf (DEPTH_LOG2=4)
module tb_fetch_pkg_buf;
`ifdef FETCH_BUF_STAT_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif
    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pkg_data = '0;
    logic        pkg_vld = 1'b0;
    logic        pkg_frm = 1'b0;
    logic [15:0] len_pkg = '0;
    logic [15:0] out_data;
    logic        out_vld, out_sop, out_eop;
    logic        out_rdy = 1'b0;
    logic [4:0]  buf_level;
    logic [15:0] drop_cnt;
    int          n_chk = 0;
    int          n_err = 0;
    int          exp_drop = 0;
    logic [17:0] sb[$];
    logic        prev_stall = 1'b0;
    logic [18:0] prev_word = '0;

    fetch_pkg_buf #(.DEPTH_LOG2(4)) dut (
        .clk_sys(clk_sys), .rst(rst), .pkg_data(pkg_data), .pkg_vld(pkg_vld),
        .pkg_frm(pkg_frm), .len_pkg(len_pkg), .out_data(out_data), .out_vld(out_vld),
        .out_sop(out_sop), .out_eop(out_eop), .out_rdy(out_rdy),
        .buf_level(buf_level), .drop_cnt(drop_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic f, input logic [15:0] d, input logic [15:0] l);
        pkg_vld  = v;
        pkg_frm  = f;
        pkg_data = d;
        len_pkg  = l;
        @(posedge clk_sys);
        #1;
        pkg_vld = 1'b0;
        pkg_frm = 1'b0;
    endtask

    task automatic send(input logic [15:0] b, input int n, input logic [15:0] l, input bit keep);
        for (int i = 0; i < n; i++) begin
            if (keep) sb.push_back({i == 0, i == n - 1, b + 16'(i)});
            cyc(1'b1, i == 0, b + 16'(i), l);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && (sb.size() != 0 || out_vld); i++) begin
            @(posedge clk_sys);
            #1;
        end
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_level"}, 32'(buf_level), 0);
    endtask

    // consumer side: pops expectations on every handshake and checks stalled words stay put
    always @(negedge clk_sys) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold", {13'd0, out_vld, out_sop, out_eop, out_data}, {13'd0, prev_word});
            if (out_vld && out_rdy) begin
                n_chk++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL extra_word: got %0h expected none", out_data);
                end
                if (sb.size() != 0) chk("word", {14'd0, out_sop, out_eop, out_data}, {14'd0, sb.pop_front()});
            end
            prev_stall = out_vld && !out_rdy;
            prev_word  = {out_vld, out_sop, out_eop, out_data};
        end
    end

    initial begin
        int k;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_vld", 32'(out_vld), 0);
        chk("rst_flags", {30'd0, out_sop, out_eop}, 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_level", 32'(buf_level), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 16'h0, 16'h0);
        chk("post_rst_vld", 32'(out_vld), 0);
        chk("post_rst_level", 32'(buf_level), 0);

        out_rdy = 1'b1;
        send(16'hA000, 4, 16'd4, 1'b1);
        k = 0;
        while (!out_vld && k < 2) begin
            @(posedge clk_sys);
            #1;
            k++;
        end
        chk("latency_vld", 32'(out_vld), 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_sys);
            #1;
            chk("consecutive", 32'(out_vld), 1);
        end
        drain("pkt_a");

        out_rdy = 1'b0;
        send(16'hB000, 10, 16'd10, 1'b1);
        send(16'hC000, 10, 16'd10, 1'b0);
        exp_drop += STAT;
        repeat (2) cyc(1'b0, 1'b0, 16'h0, 16'h0);
        chk("full_level", 32'(buf_level), 10);
        chk("full_drop", 32'(drop_cnt), exp_drop);
        out_rdy = 1'b1;
        drain("pkt_b");

        send(16'hD000, 3, 16'd4, 1'b0);
        send(16'hE000, 4, 16'd4, 1'b1);
        exp_drop += STAT;
        drain("trunc");
        chk("trunc_drop", 32'(drop_cnt), exp_drop);

        for (int i = 0; i < 12; i++) begin
            out_rdy = (i % 2) == 1;
            if (i < 3) begin
                sb.push_back({1'b1, 1'b1, 16'hF000 + 16'(i)});
                cyc(1'b1, 1'b1, 16'hF000 + 16'(i), 16'd1);
            end else begin
                cyc(1'b0, 1'b0, 16'h0, 16'd1);
            end
        end
        out_rdy = 1'b1;
        drain("toggle");

        out_rdy = 1'b0;
        send(16'h6000, 4, 16'd4, 1'b0);
        send(16'h6100, 2, 16'd4, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 16'h0, 16'd4);
        chk("pulse_vld", 32'(out_vld), 0);
        chk("pulse_level", 32'(buf_level), 0);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 16'h6102, 16'd4);
        exp_drop = 0;
        chk("after_pulse_vld", 32'(out_vld), 0);
        chk("after_pulse_level", 32'(buf_level), 0);
        chk("after_pulse_drop", 32'(drop_cnt), 0);
        out_rdy = 1'b1;
        send(16'h7000, 4, 16'd4, 1'b1);
        drain("after_pulse");

        cyc(1'b1, 1'b1, 16'h8000, 16'd0);
        exp_drop += STAT;
        chk("len0_level", 32'(buf_level), 0);
        cyc(1'b0, 1'b0, 16'h0, 16'd0);
        chk("len0_drop", 32'(drop_cnt), exp_drop);
        chk("len0_vld", 32'(out_vld), 0);
        send(16'h9000, 2, 16'd2, 1'b1);
        drain("after_len0");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
